// File: rtl/serial_adder_pkg.sv
// Shared types and reset values for the bit-serial adder sequencer.
// The state encoding is shared so that bench-side decoding matches the RTL.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_BIT   = 1'b0;

endpackage : serial_adder_pkg

// File: rtl/fa_mux_cell.sv
// One-bit full adder built from two 4:1 muxes selected by {a,b}.
// The data inputs of each mux are functions of cin only.
module fa_mux_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic [1:0] sel;
  logic [3:0] sum_data;
  logic [3:0] carry_data;

  assign sel        = {a, b};
  // Index 0 is {a,b}=00, index 3 is {a,b}=11.
  assign sum_data   = {cin, ~cin, ~cin, cin};
  assign carry_data = {1'b1, cin, cin, 1'b0};

  assign s  = sum_data[sel];
  assign co = carry_data[sel];

endmodule : fa_mux_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell, one bit per clock, LSB first.
// start/done handshake; results hold until the next accepted start.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_reg;
  logic             ovf_reg;
  logic             load;
  logic             fa_s;
  logic             fa_co;

  fa_mux_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RST_STATE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= RST_BIT;
      cnt       <= '0;
      cout_reg  <= RST_BIT;
      ovf_reg   <= RST_BIT;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state_reg == RUN) begin
        sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        carry  <= fa_co;
        // On the MSB, carry still holds the carry into the MSB.
        if (cnt == LAST) begin
          cout_reg <= fa_co;
          ovf_reg  <= carry ^ fa_co;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_sh;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the bit-serial adder at WIDTH=8.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Launch one add and wait for done; lat counts rising edges after the start edge.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_op,
                         input logic tc, output int lat);
    @(negedge clk);
    a = ta; b = tb_op; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [7:0] exp_sum, input logic exp_cout,
                              input logic exp_ovf);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 8", name, lat);
    end
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, sum, exp_sum);
    end
    checks++;
    if (cout !== exp_cout) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, cout, exp_cout);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, exp_ovf);
    end
    $display("txn %s a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
             name, a, b, cin, sum, cout, ovf, lat);
  endtask

  task automatic test_reset();
    int n_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy, done, sum, cout, ovf);
    end
    // Abort an addition mid-RUN.
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_run: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d pulses expected 0", n_done);
    end
    $display("txn reset_mid_run done_pulses=%0d", n_done);
  endtask

  task automatic test_basic();
    int lat;
    run_add(8'hFF, 8'h01, 1'b0, lat);
    check_result("ff_plus_01", lat, 8'h00, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b expected 0", busy);
    end
    run_add(8'h7F, 8'h01, 1'b0, lat);
    check_result("7f_plus_01", lat, 8'h80, 1'b0, 1'b1);
    run_add(8'h80, 8'h80, 1'b0, lat);
    check_result("80_plus_80", lat, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_start_ignored();
    int n_done;
    int lat;
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          lat = i;
          checks++;
          if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL 35_plus_4a: got sum=%h cout=%b ovf=%b expected sum=80 cout=0 ovf=1",
                     sum, cout, ovf);
          end
        end
      end
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL start_in_run_latency: got %0d expected 8", lat);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL start_in_run_ignored: got %0d done pulses expected 1", n_done);
    end
    $display("txn 35_plus_4a_cin1 sum=%h cout=%b done_pulses=%0d", sum, cout, n_done);
    // Result must persist through IDLE.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sum !== 8'h80 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_idle: got sum=%h busy=%b done=%b expected sum=80 busy=0 done=0",
                 sum, busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n1;
    int n2;
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0;
    n1 = 0;
    while (!done && n1 < 20) begin
      @(posedge clk);
      @(negedge clk);
      n1++;
    end
    checks++;
    if (n1 !== 8 || sum !== 8'h80) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d sum=%h expected lat=8 sum=80", n1, sum);
    end
    n2 = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n2++;
    end while (!done && n2 < 20);
    checks++;
    if (n2 !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 9", n2);
    end
    checks++;
    if (sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b expected sum=03 cout=0 ovf=0",
               sum, cout, ovf);
    end
    $display("txn back_to_back first_lat=%0d spacing=%0d sum=%h", n1, n2, sum);
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] exp_full;
    logic       exp_ovf;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp_full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      exp_ovf  = (ra[7] == rb[7]) && (exp_full[7] != ra[7]);
      run_add(ra, rb, rc, lat);
      check_result($sformatf("rand%0d", i), lat, exp_full[7:0], exp_full[8], exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
